// File: rtl/keypad_scanner.sv
// keypad_scanner
//
// Scans a 4x4 matrix keypad by driving one column low at a time and
// sampling the active-low rows through a 2-flop synchronizer. A key seen
// alone on its row at the end of a column's dwell is debounced; once stable
// it is reported as a one-hot {row, col} code with a single-cycle strobe.
// The release is debounced as well before scanning resumes.
//
// Handshake: there is no back-pressure. keyPulse is a one-cycle strobe
// that marks rcBits as freshly updated; keyHeld is a level that stays
// high from press acceptance until release acceptance.
//
// Ports:
//   clk        in   1  single clock, rising edge
//   reset      in   1  synchronous, active-high
//   rows       in   4  keypad rows, asynchronous, active-low
//   cols       out  4  column drive, active-low, exactly one bit low
//   rcBits     out  8  last accepted key {rowHot[3:0], colHot[3:0]}
//   keyPulse   out  1  one-cycle strobe on press acceptance
//   keyHeld    out  1  high while the accepted key is held
//   fsm_state  out  2  current scanner state, for debug/observation
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [7:0] rcBits,
    output logic       keyPulse,
    output logic       keyHeld,
    output logic [1:0] fsm_state
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DEB_ONE    = CW'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    rows_meta, rows_sync;
    logic [1:0]    col_idx, col_d;
    logic [DW-1:0] dwell, dwell_d;
    logic [CW-1:0] deb_cnt, deb_d;
    logic [3:0]    cand_row, cand_row_d;
    logic [3:0]    cand_col, cand_col_d;
    logic [7:0]    rc_d;
    logic          pulse_d, held_d;

    logic [3:0]    row_hot;
    logic          row_one_hot;

    assign row_hot     = ~rows_sync;
    // Exactly one row asserted: nonzero and clearing the lowest set bit
    // leaves nothing. Zero or multi-hot (ghosting/rollover) is rejected.
    assign row_one_hot = (row_hot != 4'd0) && ((row_hot & (row_hot - 4'd1)) == 4'd0);

    assign cols      = ~(4'b0001 << col_idx);
    assign fsm_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
            state_q   <= ST_SCAN;
            col_idx   <= 2'd0;
            dwell     <= '0;
            deb_cnt   <= '0;
            cand_row  <= 4'd0;
            cand_col  <= 4'd0;
            rcBits    <= 8'h00;
            keyPulse  <= 1'b0;
            keyHeld   <= 1'b0;
        end else begin
            rows_meta <= rows;
            rows_sync <= rows_meta;
            state_q   <= state_d;
            col_idx   <= col_d;
            dwell     <= dwell_d;
            deb_cnt   <= deb_d;
            cand_row  <= cand_row_d;
            cand_col  <= cand_col_d;
            rcBits    <= rc_d;
            keyPulse  <= pulse_d;
            keyHeld   <= held_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_idx;
        dwell_d    = dwell;
        deb_d      = deb_cnt;
        cand_row_d = cand_row;
        cand_col_d = cand_col;
        rc_d       = rcBits;
        pulse_d    = 1'b0;
        held_d     = keyHeld;

        case (state_q)
            ST_SCAN: begin
                if (dwell == DWELL_LAST) begin
                    if (row_one_hot) begin
                        // Column stays frozen so the candidate keeps being
                        // observed through the debounce window.
                        cand_row_d = row_hot;
                        cand_col_d = 4'b0001 << col_idx;
                        deb_d      = '0;
                        state_d    = ST_DEBOUNCE;
                    end else begin
                        col_d   = col_idx + 2'd1;
                        dwell_d = '0;
                    end
                end else begin
                    dwell_d = dwell + DWELL_ONE;
                end
            end

            ST_DEBOUNCE: begin
                if (row_hot != cand_row) begin
                    state_d = ST_SCAN;
                    col_d   = col_idx + 2'd1;
                    dwell_d = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    rc_d    = {cand_row, cand_col};
                    pulse_d = 1'b1;
                    held_d  = 1'b1;
                    state_d = ST_HELD;
                end else begin
                    deb_d = deb_cnt + DEB_ONE;
                end
            end

            ST_HELD: begin
                // Only the candidate row matters; other rows are ignored.
                if ((row_hot & cand_row) == 4'd0) begin
                    deb_d   = '0;
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if ((row_hot & cand_row) != 4'd0) begin
                    state_d = ST_HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    held_d  = 1'b0;
                    state_d = ST_SCAN;
                    col_d   = col_idx + 2'd1;
                    dwell_d = '0;
                end else begin
                    deb_d = deb_cnt + DEB_ONE;
                end
            end

            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

endmodule
